sensor_conditioner: RTL and testbench

- Upstream stage of the irrigation process FSM; conditions raw field sensors into the clean H1, RC and R levels that the FSM consumes.
- Filters the soil-humidity samples with a 4-tap moving average and applies a threshold with hysteresis to produce H1 (soil dry, irrigation request).
- Synchronizes and debounces the reservoir-contact and rain-sensor raw inputs into RC and R.
- Outputs are registered levels, glitch-free, in the Ck domain.

---
 rtl/sensor_pkg.sv | 19 +
 rtl/sensor_conditioner_if.sv | 25 ++
 rtl/debounce_ch.sv | 69 ++++++
 rtl/sensor_conditioner.sv | 113 +++++++++++
 tb/tb_sensor_conditioner.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_pkg.sv
// Shared constants and types for the sensor conditioner: humidity width,
// default thresholds, moving-average tap count and the debounce state enum.
package sensor_pkg;

  localparam int HUM_W           = 8;
  localparam int HUM_LO_DEF      = 60;
  localparam int HUM_HI_DEF      = 90;
  localparam int DEB_CYC_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 1000;

  localparam int TAPS      = 4;
  localparam int TAPS_LOG2 = 2;

  typedef enum logic {
    DB_STABLE,
    DB_COUNTING
  } db_state_t;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Field-side bundle of the sensor conditioner: humidity sample strobe, raw
// contacts, and the conditioned levels handed to the irrigation FSM.
interface sensor_conditioner_if;
  import sensor_pkg::*;

  logic             hum_valid;
  logic [HUM_W-1:0] hum_data;
  logic             rc_raw;
  logic             r_raw;
  logic             H1;
  logic             RC;
  logic             R;
  logic             Flt;

  modport master (
    output hum_valid, hum_data, rc_raw, r_raw,
    input  H1, RC, R, Flt
  );

  modport slave (
    input  hum_valid, hum_data, rc_raw, r_raw,
    output H1, RC, R, Flt
  );

endinterface

// File: rtl/debounce_ch.sv
// One debounced contact: 2-flop synchronizer, then the output toggles only
// after DEB_CYC consecutive synchronized cycles that disagree with it.
//   state       | meaning
//   DB_STABLE   | synchronized input agrees with out, counter idle
//   DB_COUNTING | input disagrees, counting consecutive disagreeing cycles
module debounce_ch
  import sensor_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic Ck,
  input  logic Clr,
  input  logic raw,
  output logic out
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          sync1;
  logic          sync2;
  db_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge Ck or negedge Clr) begin
    if (!Clr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= DB_STABLE;
      cnt   <= '0;
      out   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      case (state)
        DB_STABLE: begin
          if (sync2 != out) begin
            // A one-cycle filter reaches its terminal count on entry
            if (DEB_CYC == 1) begin
              out <= ~out;
              cnt <= '0;
            end else begin
              state <= DB_COUNTING;
              cnt   <= CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        DB_COUNTING: begin
          if (sync2 == out) begin
            state <= DB_STABLE;
            cnt   <= '0;
          end else if (cnt == CW'(DEB_CYC - 1)) begin
            out   <= ~out;
            state <= DB_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= DB_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions raw field sensors into H1/RC/R for the irrigation FSM.
// Define SENSOR_TIMEOUT_EN to build the silent-humidity-sensor fault (Flt).
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int HUM_LO      = HUM_LO_DEF,
  parameter int HUM_HI      = HUM_HI_DEF,
  parameter int DEB_CYC     = DEB_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                 Ck,
  input logic                 Clr,
  sensor_conditioner_if.slave bus
);

  localparam int SW = HUM_W + TAPS_LOG2;
  localparam logic [HUM_W-1:0] LO = HUM_W'(HUM_LO);
  localparam logic [HUM_W-1:0] HI = HUM_W'(HUM_HI);

  if (HUM_HI <= HUM_LO || DEB_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("sensor_conditioner: invalid threshold/debounce/timeout parameters");
  end

  logic [HUM_W-1:0] taps [TAPS];
  logic [SW-1:0]    sum;
  logic [2:0]       fill;
  logic             s1;
  logic             s2;
  logic [HUM_W-1:0] avg_q;
  logic             h1_q;
  logic             to_hit;
  logic             flt_q;

`ifdef SENSOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = !bus.hum_valid && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge Ck or negedge Clr) begin
    if (!Clr) begin
      to_cnt <= '0;
      flt_q  <= 1'b0;
    end else if (bus.hum_valid) begin
      to_cnt <= '0;
      flt_q  <= 1'b0;
    end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
      to_cnt <= to_cnt + TW'(1);
      if (to_hit) flt_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign flt_q  = 1'b0;
`endif

  // sample -> sum (n), sum -> avg_q (n+1), avg_q -> H1 (n+2)
  always_ff @(posedge Ck or negedge Clr) begin
    if (!Clr) begin
      for (int i = 0; i < TAPS; i++) taps[i] <= '0;
      sum   <= '0;
      fill  <= '0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      avg_q <= '0;
      h1_q  <= 1'b0;
    end else begin
      if (bus.hum_valid) begin
        taps[0] <= bus.hum_data;
        for (int i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
        sum <= sum + SW'(bus.hum_data) - SW'(taps[TAPS-1]);
        if (fill != 3'(TAPS)) fill <= fill + 3'd1;
      end
      s1 <= bus.hum_valid;
      s2 <= s1 && (fill == 3'(TAPS));
      if (s1 && (fill == 3'(TAPS))) avg_q <= sum[SW-1:TAPS_LOG2];
      if (s2) begin
        if (avg_q < LO)      h1_q <= 1'b1;
        else if (avg_q > HI) h1_q <= 1'b0;
      end
      // Fail-safe: a silent sensor drops the request and demands a refill
      if (to_hit) begin
        fill <= '0;
        s1   <= 1'b0;
        s2   <= 1'b0;
        h1_q <= 1'b0;
      end
    end
  end

  logic rc_q;
  logic r_q;

  debounce_ch #(.DEB_CYC(DEB_CYC)) u_rc (
    .Ck  (Ck),
    .Clr (Clr),
    .raw (bus.rc_raw),
    .out (rc_q)
  );

  debounce_ch #(.DEB_CYC(DEB_CYC)) u_r (
    .Ck  (Ck),
    .Clr (Clr),
    .raw (bus.r_raw),
    .out (r_q)
  );

  assign bus.H1  = h1_q;
  assign bus.RC  = rc_q;
  assign bus.R   = r_q;
  assign bus.Flt = flt_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: humidity model with an expected-H1
// scoreboard queue, plus exact-latency debounce and reset checks.
module tb_sensor_conditioner;
  import sensor_pkg::*;

`ifdef SENSOR_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1000;
`endif

  logic Ck;
  logic Clr;

  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  sensor_conditioner_if bus ();

  sensor_conditioner #(
    .HUM_LO      (60),
    .HUM_HI      (90),
    .DEB_CYC     (4),
    .TIMEOUT_CYC (TO)
  ) dut (
    .Ck  (Ck),
    .Clr (Clr),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];

  int m_taps[4];
  int m_fill;
  bit m_h1;
  bit m_flt;
  int m_idle;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) m_taps[i] = 0;
    m_fill = 0;
    m_h1   = 1'b0;
    m_flt  = 1'b0;
    m_idle = 0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge Ck);
`ifdef SENSOR_TIMEOUT_EN
    if (!Clr) m_idle = 0;
    else if (bus.hum_valid) begin
      m_idle = 0;
      m_flt  = 1'b0;
    end else if (m_idle < TO) begin
      m_idle++;
      if (m_idle == TO) begin
        m_flt  = 1'b1;
        m_h1   = 1'b0;
        m_fill = 0;
      end
    end
`endif
    #1;
  endtask

  task automatic model_sample(input int v);
    int avg;
    for (int i = 3; i > 0; i--) m_taps[i] = m_taps[i-1];
    m_taps[0] = v;
    if (m_fill < 4) m_fill++;
    if (m_fill == 4) begin
      avg = (m_taps[0] + m_taps[1] + m_taps[2] + m_taps[3]) / 4;
      if (avg < 60)      m_h1 = 1'b1;
      else if (avg > 90) m_h1 = 1'b0;
    end
    exp_q.push_back(m_h1);
  endtask

  task automatic send(input int v, input string tag);
    bit prev;
    prev = m_h1;
    bus.hum_valid = 1'b1;
    bus.hum_data  = v[7:0];
    model_sample(v);
    tick();
    bus.hum_valid = 1'b0;
    tick();
    chk({tag, "_hold"}, bus.H1, prev);
    tick();
    chk(tag, bus.H1, exp_q.pop_front());
    chk({tag, "_flt"}, bus.Flt, m_flt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    bus.hum_valid = 1'b0;
    bus.hum_data  = '0;
    bus.rc_raw    = 1'b0;
    bus.r_raw     = 1'b0;
    Clr           = 1'b0;
    reset_model();
    tick();
    tick();
    chk("rst_h1",  bus.H1,  1'b0);
    chk("rst_rc",  bus.RC,  1'b0);
    chk("rst_r",   bus.R,   1'b0);
    chk("rst_flt", bus.Flt, 1'b0);
    Clr = 1'b1;
    tick();

    // fill to H1=1 while RC debounces high, then reset mid-operation
    bus.rc_raw = 1'b1;
    for (int i = 0; i < 4; i++) send(40, "fill40");
    chk("rc_pre_rst", bus.RC, 1'b1);
    Clr        = 1'b0;
    bus.rc_raw = 1'b0;
    #1;
    chk("mid_rst_h1",  bus.H1,  1'b0);
    chk("mid_rst_rc",  bus.RC,  1'b0);
    chk("mid_rst_r",   bus.R,   1'b0);
    chk("mid_rst_flt", bus.Flt, 1'b0);
    reset_model();
    tick();
    Clr = 1'b1;
    for (int i = 0; i < 4; i++) send(40, "refill40");

    // hysteresis band and threshold boundaries
    for (int i = 0; i < 4; i++) send(50, "hys50");
    for (int i = 0; i < 3; i++) send(100, "hys100_band");
    send(100, "hys100_clear");
    for (int i = 0; i < 4; i++) send(60, "lo_edge60");
    send(59, "lo_set59");
    for (int i = 0; i < 4; i++) send(91, "hi_clear91");

    // debounce reject and accept on RC
    bus.rc_raw = 1'b1;
    repeat (3) tick();
    bus.rc_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rc_short_reject", bus.RC, 1'b0);
    end
    bus.rc_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rc_accept", bus.RC, (i == 6));
    end

    // bouncing rain input
    bus.r_raw = 1'b1; tick(); chk("r_bounce", bus.R, 1'b0);
    bus.r_raw = 1'b0; tick(); chk("r_bounce", bus.R, 1'b0);
    bus.r_raw = 1'b1; tick(); chk("r_bounce", bus.R, 1'b0);
    bus.r_raw = 1'b0; tick(); chk("r_bounce", bus.R, 1'b0);
    bus.r_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("r_accept", bus.R, (i == 6));
    end

    // both channels fall together
    bus.rc_raw = 1'b0;
    bus.r_raw  = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rc_fall", bus.RC, (i < 6));
      chk("r_fall",  bus.R,  (i < 6));
    end

    // simultaneous contacts and humidity sample
    begin
      bit prev;
      prev = m_h1;
      bus.rc_raw    = 1'b1;
      bus.r_raw     = 1'b1;
      bus.hum_valid = 1'b1;
      bus.hum_data  = 8'd20;
      model_sample(20);
      tick();
      bus.hum_valid = 1'b0;
      tick();
      chk("sim_h1_hold", bus.H1, prev);
      tick();
      chk("sim_h1", bus.H1, exp_q.pop_front());
      tick();
      tick();
      chk("sim_rc_early", bus.RC, 1'b0);
      chk("sim_r_early",  bus.R,  1'b0);
      tick();
      chk("sim_rc", bus.RC, 1'b1);
      chk("sim_r",  bus.R,  1'b1);
    end
    for (int i = 0; i < 3; i++) send(20, "post_sim20");
    for (int i = 0; i < 4; i++) send(30, "pre_to30");

`ifdef SENSOR_TIMEOUT_EN
    // silent sensor: fault raises, H1 drops, and four fresh samples rearm H1
    for (int i = 0; i < TO; i++) begin
      tick();
      chk("to_flt", bus.Flt, m_flt);
      chk("to_h1",  bus.H1,  m_h1);
    end
    chk("to_flt_set", bus.Flt, 1'b1);
    chk("to_h1_drop", bus.H1,  1'b0);
    for (int i = 0; i < 4; i++) send(40, "to_refill40");
`endif

    chk("end_flt", bus.Flt, m_flt);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
